iterative_signed_or_unsigned_mul: RTL and testbench

- Multi-cycle radix-2 shift-add multiplier, n-bit operands, 2n-bit product.
- Signedness is selected independently per operand, so signed×signed, signed×unsigned, unsigned×signed and unsigned×unsigned are all supported.
- Sits between a valid/ready producer and a valid/ready consumer. Trades the single-cycle n×n array for n cycles of latency and one adder.

---
 rtl/iterative_signed_or_unsigned_mul.sv | 145 ++++++++++++++
 tb/tb_iterative_signed_or_unsigned_mul.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_signed_or_unsigned_mul.sv
// -----------------------------------------------------------------------------
// iterative_signed_or_unsigned_mul
//
// Radix-2 shift-add multiplier. n-bit operands, 2n-bit product, one adder,
// n cycles of iteration per product. Each operand independently selects
// two's-complement or unsigned interpretation. The datapath works on unsigned
// magnitudes; the product sign is re-applied on the last iteration.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   up_valid    operands a/b/a_signed/b_signed are valid
//   up_ready    block can accept operands this cycle (combinational)
//   a, b        multiplicand, multiplier (n bits)
//   a_signed    1: a is two's complement, 0: unsigned
//   b_signed    1: b is two's complement, 0: unsigned
//   down_valid  res holds a finished product
//   down_ready  consumer takes res this cycle
//   res         product (2n bits), two's complement if either operand signed
// -----------------------------------------------------------------------------
module iterative_signed_or_unsigned_mul #(
  parameter int n = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [n-1:0]     a,
  input  logic [n-1:0]     b,
  input  logic             a_signed,
  input  logic             b_signed,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [2*n-1:0]   res
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CW-1:0]    cnt;
  logic [2*n-1:0]   acc;
  logic [2*n-1:0]   mcand;
  logic [n-1:0]     mplier;
  logic             neg_q;

  logic             accept;
  logic             last_iter;
  logic [2*n-1:0]   addend;
  logic [2*n-1:0]   acc_sum;
  logic [n-1:0]     mag_a;
  logic [n-1:0]     mag_b;
  logic             neg_a;
  logic             neg_b;

  // Unsigned magnitude of an operand. The most negative signed value maps to
  // 2^(n-1), which still fits in n bits because the result is read unsigned.
  function automatic logic [n-1:0] magnitude(input logic [n-1:0] v,
                                             input logic          is_neg);
    return is_neg ? (~v + n'(1)) : v;
  endfunction

  // Re-apply the product sign. Negating zero wraps back to zero, so a zero
  // product never comes out as a negative pattern.
  function automatic logic [2*n-1:0] apply_sign(input logic [2*n-1:0] v,
                                                input logic            is_neg);
    return is_neg ? (~v + (2*n)'(1)) : v;
  endfunction

  always_comb begin
    neg_a     = a_signed & a[n-1];
    neg_b     = b_signed & b[n-1];
    mag_a     = magnitude(a, neg_a);
    mag_b     = magnitude(b, neg_b);

    up_ready   = (state == IDLE) || ((state == DONE) && down_ready);
    down_valid = (state == DONE);
    accept     = up_valid & up_ready;

    last_iter = (state == BUSY) && (cnt == CNT_LAST);
    addend    = mplier[0] ? mcand : '0;
    acc_sum   = acc + addend;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        // Accept and drain in the same edge skips the IDLE bubble.
        if (accept)          state_nxt = BUSY;
        else if (down_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --- operand capture / iteration / result write ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg_q  <= 1'b0;
      res    <= '0;
    end else if (accept) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{n{1'b0}}, mag_a};
      mplier <= mag_b;
      neg_q  <= neg_a ^ neg_b;
    end else if (state == BUSY) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last_iter) begin
        res <= apply_sign(acc_sum, neg_q);
      end
    end
  end

endmodule

// File: tb/tb_iterative_signed_or_unsigned_mul.sv
module tb_iterative_signed_or_unsigned_mul;

  localparam int N = 8;

  logic           clk;
  logic           rst_n;
  logic           up_valid;
  logic           up_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           a_signed;
  logic           b_signed;
  logic           down_valid;
  logic           down_ready;
  logic [2*N-1:0] res;

  int errors;
  int checks;

  iterative_signed_or_unsigned_mul #(.n(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .a          (a),
    .b          (b),
    .a_signed   (a_signed),
    .b_signed   (b_signed),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .res        (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           as;
    logic           bs;
    logic [2*N-1:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic xs, input logic ys);
    logic signed [N:0]     sx;
    logic signed [N:0]     sy;
    logic signed [2*N+1:0] p;
    sx = {xs & x[N-1], x};
    sy = {ys & y[N-1], y};
    p  = sx * sy;
    return p[2*N-1:0];
  endfunction

  // Called one time unit after a rising edge with the DUT idle and down_ready=1.
  task automatic run_vec(input int idx, input vec_t v);
    int k;
    a = v.a; b = v.b; a_signed = v.as; b_signed = v.bs;
    up_valid = 1'b1;
    @(posedge clk); #1;
    up_valid = 1'b0;
    // Operands must be ignored after the accept edge.
    a = ~v.a; b = ~v.b; a_signed = ~v.as; b_signed = ~v.bs;
    k = 0;
    while (!down_valid && k < N + 5) begin
      @(posedge clk); #1;
      k++;
    end
    check($sformatf("vec%0d_latency", idx), k, N);
    check($sformatf("vec%0d_res", idx), res, v.exp);
    @(posedge clk); #1;
  endtask

  logic [2*N-1:0] sb_q[$];

  initial begin
    errors = 0;
    checks = 0;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01};
    vecs[1]  = '{8'hFF, 8'hFF, 1'b1, 1'b1, 16'h0001};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFF01};
    vecs[3]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFF01};
    vecs[4]  = '{8'h80, 8'h80, 1'b1, 1'b1, 16'h4000};
    vecs[5]  = '{8'h80, 8'hFF, 1'b1, 1'b0, 16'h8080};
    vecs[6]  = '{8'h7F, 8'h80, 1'b1, 1'b1, 16'hC080};
    vecs[7]  = '{8'h03, 8'h05, 1'b0, 1'b0, 16'h000F};
    vecs[8]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 16'h0000};
    vecs[9]  = '{8'h80, 8'h01, 1'b1, 1'b1, 16'hFF80};
    vecs[10] = '{8'hFF, 8'h80, 1'b0, 1'b1, 16'h8080};
    vecs[11] = '{8'h7F, 8'h7F, 1'b1, 1'b1, 16'h3F01};
    vecs[12] = '{8'hFF, 8'h00, 1'b1, 1'b0, 16'h0000};
    vecs[13] = '{8'h80, 8'hFF, 1'b0, 1'b0, 16'h7F80};
    vecs[14] = '{8'hFE, 8'h03, 1'b1, 1'b0, 16'hFFFA};

    rst_n = 1'b0; up_valid = 1'b0; down_ready = 1'b1;
    a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_up_ready", up_ready, 1'b1);
    check("reset_down_valid", down_valid, 1'b0);
    check("reset_res", res, '0);

    // Directed table.
    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Backpressure: 3x5 held for 5 cycles, new operands offered but refused.
    down_ready = 1'b0;
    a = 8'd3; b = 8'd5; a_signed = 1'b0; b_signed = 1'b0; up_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'd9; b = 8'd9;
    begin
      int k;
      k = 0;
      while (!down_valid && k < N + 5) begin
        @(posedge clk); #1;
        k++;
      end
      check("bp_latency", k, N);
    end
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid_c%0d", c), down_valid, 1'b1);
      check($sformatf("bp_res_c%0d", c), res, 16'd15);
      check($sformatf("bp_up_ready_c%0d", c), up_ready, 1'b0);
      @(posedge clk); #1;
    end
    up_valid = 1'b0;
    down_ready = 1'b1;
    #1;
    check("bp_up_ready_drain", up_ready, 1'b1);
    @(posedge clk); #1;
    check("bp_idle_valid", down_valid, 1'b0);
    check("bp_idle_res_kept", res, 16'd15);
    check("bp_idle_up_ready", up_ready, 1'b1);

    // Back-to-back stream with constant down_ready/up_valid.
    begin
      logic [N-1:0]   oa [3];
      logic [N-1:0]   ob [3];
      logic           oas[3];
      logic           obs[3];
      logic [2*N-1:0] oexp[3];
      int             pulse_cyc[$];
      logic [2*N-1:0] pulse_res[$];
      int             idx;
      logic           acc_now;
      logic           dv_now;
      logic [2*N-1:0] r_now;
      oa[0] = 8'd2;  ob[0] = 8'd3;   oas[0] = 1'b0; obs[0] = 1'b0; oexp[0] = 16'd6;
      oa[1] = 8'hFC; ob[1] = 8'd5;   oas[1] = 1'b1; obs[1] = 1'b1; oexp[1] = 16'hFFEC;
      oa[2] = 8'd0;  ob[2] = 8'd200; oas[2] = 1'b0; obs[2] = 1'b0; oexp[2] = 16'd0;
      idx = 0;
      a = oa[0]; b = ob[0]; a_signed = oas[0]; b_signed = obs[0]; up_valid = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
        @(negedge clk);
        acc_now = up_valid & up_ready;
        dv_now  = down_valid;
        r_now   = res;
        @(posedge clk); #1;
        if (dv_now) begin
          pulse_cyc.push_back(cyc);
          pulse_res.push_back(r_now);
        end
        if (acc_now) begin
          idx++;
          if (idx < 3) begin
            a = oa[idx]; b = ob[idx]; a_signed = oas[idx]; b_signed = obs[idx];
          end else begin
            up_valid = 1'b0;
          end
        end
      end
      check("b2b_count", pulse_cyc.size(), 3);
      if (pulse_cyc.size() == 3) begin
        check("b2b_first_cycle", pulse_cyc[0], N + 1);
        for (int i = 0; i < 3; i++) begin
          check($sformatf("b2b_res%0d", i), pulse_res[i], oexp[i]);
          if (i > 0) check($sformatf("b2b_gap%0d", i), pulse_cyc[i] - pulse_cyc[i-1], N + 1);
        end
      end
    end

    // Asynchronous reset in the middle of an operation.
    @(posedge clk); #1;
    a = 8'd3; b = 8'd5; a_signed = 1'b0; b_signed = 1'b0; up_valid = 1'b1;
    @(posedge clk); #1;
    up_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_down_valid", down_valid, 1'b0);
    check("midrst_up_ready", up_ready, 1'b1);
    check("midrst_res", res, '0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < N + 3; c++) begin
        @(posedge clk); #1;
        if (down_valid) seen = 1'b1;
      end
      check("midrst_no_result", seen, 1'b0);
    end

    // Random traffic against the reference model.
    begin
      int got;
      int cyc;
      logic acc_now;
      logic xfer_now;
      logic [2*N-1:0] e;
      got = 0;
      cyc = 0;
      while (got < 500 && cyc < 20000) begin
        @(negedge clk);
        up_valid   = ($urandom_range(0, 1) == 1);
        down_ready = ($urandom_range(0, 3) != 0);
        a_signed   = $urandom_range(0, 1) == 1;
        b_signed   = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 7))
          0:       a = 8'h80;
          1:       a = 8'hFF;
          2:       a = 8'h00;
          default: a = N'($urandom);
        endcase
        case ($urandom_range(0, 7))
          0:       b = 8'h80;
          1:       b = 8'hFF;
          2:       b = 8'h00;
          default: b = N'($urandom);
        endcase
        #1;
        acc_now  = up_valid & up_ready;
        xfer_now = down_valid & down_ready;
        if (xfer_now) begin
          if (sb_q.size() == 0) begin
            check("rand_unexpected_result", 1'b1, 1'b0);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("rand_res%0d", got), res, e);
          end
          got++;
        end
        if (acc_now) sb_q.push_back(model(a, b, a_signed, b_signed));
        cyc++;
      end
      up_valid = 1'b0;
      check("rand_done", got, 500);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
